// File: rtl/pc_sequencer.sv
// pc_sequencer: run-control sequencer that steers the PC's init/branch_en/target inputs,
// runs the start/done handshake and counts RUN-state cycles.
`default_nettype none

module pc_sequencer #(
  parameter int              PC_W        = 10,
  parameter int              INIT_CYCLES = 2,
  parameter logic [PC_W-1:0] MAX_PC      = 10'h3FF,
  parameter int              CNT_W       = 16
) (
  input  logic             CLK,
  input  logic             init_n,
  input  logic             start,
  input  logic [PC_W-1:0]  pc,
  input  logic             br_taken,
  input  logic [PC_W-1:0]  br_offset,
  input  logic             stall_req,
  input  logic             halt_req,
  output logic             pc_init,
  output logic             pc_branch_en,
  output logic [PC_W-1:0]  pc_target,
  output logic             running,
  output logic             done,
  output logic [CNT_W-1:0] cycle_count
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_INIT = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [3:0] INIT_LAST = 4'(INIT_CYCLES - 1);

  state_t     state;
  logic [3:0] init_cnt;
  logic       at_end;
  logic       end_run;

  // Falling off the last address only ends the run when nothing else claims this cycle.
  assign at_end  = !stall_req && !br_taken && (pc == MAX_PC);
  assign end_run = halt_req || at_end;

  always_ff @(posedge CLK or negedge init_n) begin
    if (!init_n) begin
      state       <= S_IDLE;
      init_cnt    <= 4'd0;
      cycle_count <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state       <= S_INIT;
            init_cnt    <= 4'd0;
            cycle_count <= '0;
          end
        end
        S_INIT: begin
          if (init_cnt == INIT_LAST) begin
            state    <= S_RUN;
            init_cnt <= 4'd0;
          end else begin
            init_cnt <= init_cnt + 4'd1;
          end
        end
        S_RUN: begin
          if (cycle_count != '1) cycle_count <= cycle_count + CNT_W'(1);
          if (end_run) state <= S_DONE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // PC controls are combinational so the PC's next edge reflects this cycle's decision.
  // Freezing is a branch by zero since the PC has no hold input.
  always_comb begin
    pc_init      = 1'b0;
    pc_branch_en = 1'b0;
    pc_target    = '0;
    case (state)
      S_IDLE, S_INIT: pc_init = 1'b1;
      S_RUN: begin
        if (halt_req || stall_req) begin
          pc_branch_en = 1'b1;
        end else if (br_taken) begin
          pc_branch_en = 1'b1;
          pc_target    = br_offset;
        end else if (pc == MAX_PC) begin
          pc_branch_en = 1'b1;
        end
      end
      S_DONE:  pc_branch_en = 1'b1;
      default: pc_init = 1'b1;
    endcase
  end

  assign running = (state == S_INIT) || (state == S_RUN);
  assign done    = (state == S_DONE);

endmodule

`default_nettype wire

// File: tb/tb_pc_sequencer.sv
// Directed testbench for pc_sequencer driving a behavioural PC register.
`default_nettype none

module tb_pc_sequencer;

  logic       clk = 1'b0;
  logic       init_n, start, br_taken, stall_req, halt_req;
  logic [9:0] br_offset;
  logic [9:0] pc_m = 10'h2AA;
  logic       pc_init, br_en, running, done;
  logic [9:0] tgt;
  logic [15:0] cnt;
  logic       s_pc_init, s_br_en, s_running, s_done;
  logic [9:0] s_tgt;
  logic [3:0] s_cnt;
  logic [3:0] ctl;
  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  pc_sequencer #(.PC_W(10), .INIT_CYCLES(2), .MAX_PC(10'h00F), .CNT_W(16)) dut (
    .CLK(clk), .init_n(init_n), .start(start), .pc(pc_m), .br_taken(br_taken),
    .br_offset(br_offset), .stall_req(stall_req), .halt_req(halt_req),
    .pc_init(pc_init), .pc_branch_en(br_en), .pc_target(tgt),
    .running(running), .done(done), .cycle_count(cnt));

  // Narrow-counter copy fed identical stimulus, used only for the saturation check.
  pc_sequencer #(.PC_W(10), .INIT_CYCLES(2), .MAX_PC(10'h00F), .CNT_W(4)) u_sat (
    .CLK(clk), .init_n(init_n), .start(start), .pc(pc_m), .br_taken(br_taken),
    .br_offset(br_offset), .stall_req(stall_req), .halt_req(halt_req),
    .pc_init(s_pc_init), .pc_branch_en(s_br_en), .pc_target(s_tgt),
    .running(s_running), .done(s_done), .cycle_count(s_cnt));

  // Behavioural PC register with init/branch_en/target inputs and no hold.
  always @(posedge clk) begin
    if (pc_init)    pc_m <= 10'd0;
    else if (br_en) pc_m <= pc_m + tgt;
    else            pc_m <= pc_m + 10'd1;
  end

  assign ctl = {pc_init, br_en, running, done};

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic test_reset();
    init_n = 1'b0; start = 1'b0; br_taken = 1'b0; stall_req = 1'b0;
    halt_req = 1'b0; br_offset = 10'd0;
    #1;
    vectors++;
    if (ctl !== 4'b1000) begin miscompares++; $display("FAIL reset_ctl: got %b expected 1000", ctl); end
    vectors++;
    if (tgt !== 10'd0 || cnt !== 16'd0) begin
      miscompares++; $display("FAIL reset_vals: target %h count %0d expected 0 0", tgt, cnt);
    end
    tick; tick; init_n = 1'b1; #1;
    vectors++;
    if (pc_m !== 10'd0 || ctl !== 4'b1000) begin
      miscompares++; $display("FAIL idle_after_reset: pc %h ctl %b expected 000 1000", pc_m, ctl);
    end
  endtask

  task automatic test_start_run();
    tick; start = 1'b1; #1;
    vectors++;
    if (ctl !== 4'b1000) begin miscompares++; $display("FAIL idle_start: got %b expected 1000", ctl); end
    tick; start = 1'b0; #1;
    vectors++;
    if (ctl !== 4'b1010) begin miscompares++; $display("FAIL init1: got %b expected 1010", ctl); end
    tick; #1;
    vectors++;
    if (ctl !== 4'b1010) begin miscompares++; $display("FAIL init2: got %b expected 1010", ctl); end
    tick; #1;
    vectors++;
    if (ctl !== 4'b0010 || pc_m !== 10'd0 || cnt !== 16'd0) begin
      miscompares++; $display("FAIL run_first: ctl %b pc %h count %0d expected 0010 000 0", ctl, pc_m, cnt);
    end
    for (int k = 1; k <= 3; k++) begin
      tick; #1;
      vectors++;
      if (pc_m !== 10'(k) || br_en !== 1'b0 || cnt !== 16'(k)) begin
        miscompares++; $display("FAIL run_inc: pc %h en %b count %0d expected %0d 0 %0d", pc_m, br_en, cnt, k, k);
      end
    end
  endtask

  task automatic test_branch();
    tick; tick; br_taken = 1'b1; br_offset = 10'h3FD; #1;
    vectors++;
    if (pc_m !== 10'd5 || br_en !== 1'b1 || tgt !== 10'h3FD) begin
      miscompares++; $display("FAIL branch: pc %h en %b target %h expected 005 1 3fd", pc_m, br_en, tgt);
    end
    tick; br_taken = 1'b0; #1;
    vectors++;
    if (pc_m !== 10'd2 || br_en !== 1'b0 || cnt !== 16'd6) begin
      miscompares++; $display("FAIL branch_dest: pc %h en %b count %0d expected 002 0 6", pc_m, br_en, cnt);
    end
    tick; #1;
    vectors++;
    if (pc_m !== 10'd3) begin miscompares++; $display("FAIL branch_inc: got %h expected 003", pc_m); end
  endtask

  task automatic test_stall();
    for (int i = 0; i < 4; i++) tick;
    stall_req = 1'b1; br_taken = 1'b1; br_offset = 10'd5; #1;
    vectors++;
    if (pc_m !== 10'd7 || br_en !== 1'b1 || tgt !== 10'd0 || cnt !== 16'd11) begin
      miscompares++; $display("FAIL stall_prio: pc %h en %b target %h count %0d expected 007 1 000 11", pc_m, br_en, tgt, cnt);
    end
    for (int i = 1; i <= 2; i++) begin
      tick; #1;
      vectors++;
      if (pc_m !== 10'd7 || tgt !== 10'd0 || cnt !== 16'(11 + i)) begin
        miscompares++; $display("FAIL stall_hold: pc %h target %h count %0d expected 007 000 %0d", pc_m, tgt, cnt, 11 + i);
      end
    end
    tick; stall_req = 1'b0; br_taken = 1'b0; #1;
    vectors++;
    if (pc_m !== 10'd7 || br_en !== 1'b0 || cnt !== 16'd14) begin
      miscompares++; $display("FAIL stall_release: pc %h en %b count %0d expected 007 0 14", pc_m, br_en, cnt);
    end
  endtask

  task automatic test_halt();
    tick; tick; halt_req = 1'b1; stall_req = 1'b1; #1;
    vectors++;
    if (pc_m !== 10'd9 || ctl !== 4'b0110 || tgt !== 10'd0) begin
      miscompares++; $display("FAIL halt: pc %h ctl %b target %h expected 009 0110 000", pc_m, ctl, tgt);
    end
    tick; halt_req = 1'b0; stall_req = 1'b0; #1;
    vectors++;
    if (ctl !== 4'b0101 || pc_m !== 10'd9 || cnt !== 16'd17) begin
      miscompares++; $display("FAIL halt_done: ctl %b pc %h count %0d expected 0101 009 17", ctl, pc_m, cnt);
    end
    vectors++;
    if (s_cnt !== 4'hF) begin miscompares++; $display("FAIL saturate: got %h expected f", s_cnt); end
    for (int i = 0; i < 3; i++) begin
      tick; #1;
      vectors++;
      if (pc_m !== 10'd9 || cnt !== 16'd17 || ctl !== 4'b0101) begin
        miscompares++; $display("FAIL done_hold: pc %h count %0d ctl %b expected 009 17 0101", pc_m, cnt, ctl);
      end
    end
  endtask

  task automatic test_max_pc();
    start = 1'b1; #1;
    tick; #1;
    vectors++;
    if (ctl !== 4'b1010 || cnt !== 16'd0 || pc_m !== 10'd9) begin
      miscompares++; $display("FAIL restart: ctl %b count %0d pc %h expected 1010 0 009", ctl, cnt, pc_m);
    end
    tick; #1;
    tick; start = 1'b0; #1;
    vectors++;
    if (pc_m !== 10'd0 || ctl !== 4'b0010) begin
      miscompares++; $display("FAIL restart_run: pc %h ctl %b expected 000 0010", pc_m, ctl);
    end
    for (int k = 1; k <= 15; k++) tick;
    #1;
    vectors++;
    if (pc_m !== 10'd15 || br_en !== 1'b1 || tgt !== 10'd0) begin
      miscompares++; $display("FAIL max_freeze: pc %h en %b target %h expected 00f 1 000", pc_m, br_en, tgt);
    end
    tick; #1;
    vectors++;
    if (ctl !== 4'b0101 || pc_m !== 10'd15 || cnt !== 16'd16) begin
      miscompares++; $display("FAIL max_done: ctl %b pc %h count %0d expected 0101 00f 16", ctl, pc_m, cnt);
    end
  endtask

  task automatic test_max_branch();
    tick; start = 1'b1;
    tick; start = 1'b0;
    tick; tick;
    for (int k = 1; k <= 15; k++) tick;
    br_taken = 1'b1; br_offset = 10'h3FC; #1;
    vectors++;
    if (pc_m !== 10'd15 || br_en !== 1'b1 || tgt !== 10'h3FC) begin
      miscompares++; $display("FAIL max_branch: pc %h en %b target %h expected 00f 1 3fc", pc_m, br_en, tgt);
    end
    tick; br_taken = 1'b0; #1;
    vectors++;
    if (pc_m !== 10'd11 || ctl !== 4'b0010) begin
      miscompares++; $display("FAIL max_branch_dest: pc %h ctl %b expected 00b 0010", pc_m, ctl);
    end
  endtask

  task automatic test_async_reset();
    tick; #2; init_n = 1'b0; #1;
    vectors++;
    if (ctl !== 4'b1000 || cnt !== 16'd0) begin
      miscompares++; $display("FAIL async_reset: ctl %b count %0d expected 1000 0", ctl, cnt);
    end
    @(posedge clk); #1;
    vectors++;
    if (pc_m !== 10'd0) begin miscompares++; $display("FAIL async_pc: got %h expected 000", pc_m); end
    tick; init_n = 1'b1; #1;
    vectors++;
    if (ctl !== 4'b1000) begin miscompares++; $display("FAIL post_reset: got %b expected 1000", ctl); end
  endtask

  initial begin
    test_reset();
    test_start_run();
    test_branch();
    test_stall();
    test_halt();
    test_max_pc();
    test_max_branch();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Run-control sequencer that drives the program counter's `init`, `branch_en` and `target` inputs from one place.
- Owns start/done handshake with the test harness, PC initialisation, stall freezing, branch steering and end-of-program/halt detection.
- Counts executed cycles for performance reporting.
- Sits between the decode/hazard logic and the PC register.

Parameters:
- PC_W, 10, width of PC and target buses.
- INIT_CYCLES, 2, number of cycles `pc_init` stays asserted after start (legal 1..15).
- MAX_PC, 10'h3FF, last legal instruction address; reaching it without a branch ends the program.
- CNT_W, 16, width of the cycle counter.

Ports:
- CLK  input  1  clock, all state on rising edge.
- init_n  input  1  asynchronous active-low reset.
- start  input  1  request to (re)run the program; sampled only in IDLE and DONE.
- pc  input  PC_W  current PC value (registered output of the PC).
- br_taken  input  1  decode reports taken branch this cycle.
- br_offset  input  PC_W  two's-complement PC-relative offset for the taken branch.
- stall_req  input  1  hazard logic requests the PC be held this cycle.
- halt_req  input  1  halt instruction decoded this cycle.
- pc_init  output  1  to PC `init`.
- pc_branch_en  output  1  to PC `branch_en`.
- pc_target  output  PC_W  to PC `target`.
- running  output  1  high in INIT and RUN.
- done  output  1  high in DONE.
- cycle_count  output  CNT_W  RUN-state cycles since last start.

Behaviour:
- Reset (init_n low, asynchronous): state=IDLE, init counter=0, cycle_count=0.
  - Outputs during reset: pc_init=1, pc_branch_en=0, pc_target=0, running=0, done=0.
- PC control outputs are combinational from state and current inputs, so the PC's next-edge update reflects this cycle's decision (zero added latency).
- The PC has no hold input; "freeze" means pc_branch_en=1 with pc_target=0 (PC <= PC+0).
- States:
  - IDLE: pc_init=1. When start=1, go to INIT and clear cycle_count.
  - INIT: pc_init=1, branch_en=0. Counter runs 0..INIT_CYCLES-1, then go to RUN. The PC is guaranteed 0 on the first RUN cycle. start and all decode inputs are ignored.
  - RUN: pc_init=0. Priority is halt_req > stall_req > br_taken > default.
    - halt_req: freeze; next state DONE.
    - stall_req: freeze; stay in RUN.
    - br_taken: branch_en=1, target=br_offset. No range check; the sum wraps modulo 2^PC_W.
    - Default: branch_en=0 (PC+1). If pc==MAX_PC, freeze instead and go to DONE (no wrap past MAX_PC).
    - A taken branch at pc==MAX_PC is honoured; it does not end the program.
  - DONE: pc_init=0, freeze every cycle, done=1, running=0, cycle_count held. When start=1, go to INIT, clear cycle_count, drop done next cycle.
- cycle_count increments on every RUN cycle, including stall and halt cycles. It saturates at all-ones and does not wrap.
- start is level-sampled. Holding start high through INIT/RUN has no effect. Holding it in DONE restarts immediately.
- Reset mid-RUN: asynchronous return to IDLE. The PC is re-zeroed via pc_init on the following edge.
- State encoding is one-hot or binary (implementer's choice). Unused encodings recover to IDLE.

Test Plan:
- Reset then start pulse at cycle 0 -> pc_init high for cycles 1–2 (INIT_CYCLES=2). RUN from cycle 3 with pc=0. PC then reads 1,2,3 on successive cycles with pc_branch_en=0.
- In RUN at pc=5, assert br_taken with br_offset=10'h3FD (-3) for one cycle -> pc_branch_en=1 and pc_target=3FD that cycle. PC becomes 2 next cycle, then increments.
- At pc=7, assert stall_req for 3 cycles together with br_taken=1 -> stall wins: pc_target=0, PC holds 7 for 3 cycles. cycle_count still advances by 3.
- At pc=9, assert halt_req and stall_req together -> freeze. done=1 next cycle, PC stays 9 indefinitely, cycle_count frozen. A later start returns PC to 0 and clears cycle_count.
- With MAX_PC=10'h00F and no branches -> PC runs 0..15, freezes at 15, done asserts. Repeat with a taken branch (offset -4) at pc=15 -> PC=11 and run continues.
- Drop init_n asynchronously mid-RUN (between edges) -> pc_init=1 and running=0 immediately. PC is 0 after the next edge. Saturation check: force cycle_count to all-ones -1 and run 3 cycles -> reads all-ones.
